mux_nto1_reg: RTL and testbench

MUX_NTO1_REG -- requirements
Module: mux_nto1_reg

---
 rtl/mux_nto1_reg.sv | 197 +++++++++++++++++++
 tb/tb_mux_nto1_reg.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_reg.sv
// -----------------------------------------------------------------------------
// mux_nto1_reg
//
// Registered N-to-1 channel multiplexer with two selection modes and a
// single-cycle latency. In explicit mode (ARB=0) the channel is named by
// select_i. In round-robin mode (ARB=1) the channel is chosen among the valid
// inputs, starting just after the last granted channel.
//
// Parameters
//   SIZE   data width per channel
//   NUM    number of input channels (2..16)
//   SEL_W  select / pointer width, 2**SEL_W >= NUM
//   ARB    0 = explicit select, 1 = round-robin among valid channels
//
// Ports
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-low reset
//   data_i     packed channel data, channel k at [k*SIZE +: SIZE]
//   valid_i    per-channel valid
//   select_i   channel index (explicit mode only)
//   stall_i    hold all registered state
//   flush_i    load a bubble (takes precedence over stall_i)
//   data_o     registered selected data
//   valid_o    registered valid of the captured channel
//   grant_o    registered one-hot of the captured channel, zero if none
//   sel_err_o  registered flag: select_i was out of range when captured
// -----------------------------------------------------------------------------
module mux_nto1_reg #(
  parameter int SIZE  = 32,
  parameter int NUM   = 4,
  parameter int SEL_W = 2,
  parameter int ARB   = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM*SIZE-1:0] data_i,
  input  logic [NUM-1:0]      valid_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                stall_i,
  input  logic                flush_i,
  output logic [SIZE-1:0]     data_o,
  output logic                valid_o,
  output logic [NUM-1:0]      grant_o,
  output logic                sel_err_o
);

  // Registered state (stage 1)
  logic [SIZE-1:0]  data_p1;
  logic             vld_p1;
  logic [NUM-1:0]   grant_p1;
  logic             err_p1;
  logic [SEL_W-1:0] ptr_p1;

  // Next-state values
  logic [SIZE-1:0]  data_nxt;
  logic             vld_nxt;
  logic [NUM-1:0]   grant_nxt;
  logic             err_nxt;
  logic [SEL_W-1:0] ptr_nxt;

  // Unpacked channel view
  logic [SIZE-1:0]  ch_data [NUM];

  // Explicit-select decode
  logic             sel_in_range;
  logic [SIZE-1:0]  sel_data;
  logic             sel_vld;
  logic [NUM-1:0]   sel_onehot;

  // Round-robin search
  logic             rr_found;
  logic [SEL_W-1:0] rr_idx;
  logic [SIZE-1:0]  rr_data;
  logic [NUM-1:0]   rr_onehot;
  int               rr_dist;
  int               rr_best;

  // ---------------------------------------------------------------------------
  // Stage 0: combinational channel selection from the current inputs
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      ch_data[k] = data_i[k*SIZE +: SIZE];
    end
  end

  // Decode by comparison rather than by indexing so that an out-of-range
  // select (possible when NUM < 2**SEL_W) never addresses a missing channel.
  always_comb begin
    sel_in_range = (int'(select_i) < NUM);
    sel_data     = '0;
    sel_vld      = 1'b0;
    sel_onehot   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_data      = ch_data[k];
        sel_vld       = valid_i[k];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  // Each channel's position in the search order is its distance after the
  // pointer: ptr+1 has distance 0, ptr itself has distance NUM-1. The valid
  // channel with the smallest distance wins, which gives the wrap-around
  // order without needing a rotated copy of valid_i.
  always_comb begin
    rr_found  = 1'b0;
    rr_idx    = ptr_p1;
    rr_data   = '0;
    rr_onehot = '0;
    rr_best   = NUM;
    rr_dist   = 0;
    for (int k = 0; k < NUM; k++) begin
      rr_dist = k - int'(ptr_p1) - 1;
      if (rr_dist < 0) begin
        rr_dist = rr_dist + NUM;
      end
      if (valid_i[k] && (rr_dist < rr_best)) begin
        rr_best  = rr_dist;
        rr_found = 1'b1;
        rr_idx   = SEL_W'(k);
        rr_data  = ch_data[k];
      end
    end
    for (int k = 0; k < NUM; k++) begin
      rr_onehot[k] = rr_found && (rr_idx == SEL_W'(k));
    end
  end

  // Precedence below the reset: flush, then stall, then normal capture.
  always_comb begin
    data_nxt  = data_p1;
    vld_nxt   = vld_p1;
    grant_nxt = grant_p1;
    err_nxt   = err_p1;
    ptr_nxt   = ptr_p1;
    if (flush_i) begin
      data_nxt  = '0;
      vld_nxt   = 1'b0;
      grant_nxt = '0;
      err_nxt   = 1'b0;
    end else if (stall_i) begin
      data_nxt  = data_p1;
    end else if (ARB == 0) begin
      if (sel_in_range) begin
        data_nxt  = sel_data;
        vld_nxt   = sel_vld;
        grant_nxt = sel_onehot;
        err_nxt   = 1'b0;
      end else begin
        data_nxt  = '0;
        vld_nxt   = 1'b0;
        grant_nxt = '0;
        err_nxt   = 1'b1;
      end
    end else begin
      err_nxt = 1'b0;
      if (rr_found) begin
        data_nxt  = rr_data;
        vld_nxt   = 1'b1;
        grant_nxt = rr_onehot;
        ptr_nxt   = rr_idx;
      end else begin
        // Idle cycle: data and pointer keep their last values.
        vld_nxt   = 1'b0;
        grant_nxt = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: output register
  // ---------------------------------------------------------------------------
  // Pointer resets to the last channel so the first search starts at channel 0.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      grant_p1 <= '0;
      err_p1   <= 1'b0;
      ptr_p1   <= SEL_W'(NUM - 1);
    end else begin
      data_p1  <= data_nxt;
      vld_p1   <= vld_nxt;
      grant_p1 <= grant_nxt;
      err_p1   <= err_nxt;
      ptr_p1   <= ptr_nxt;
    end
  end

  assign data_o    = data_p1;
  assign valid_o   = vld_p1;
  assign grant_o   = grant_p1;
  assign sel_err_o = err_p1;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Testbench for mux_nto1_reg. Three instances share the stimulus:
//   u_sel : ARB=0, NUM=4     u_rr : ARB=1, NUM=4     u_n3 : ARB=0, NUM=3
// A reference model computes the expected outputs when inputs are applied
// and queues them; a monitor pops and compares one entry per captured edge.
module tb_mux_nto1_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i   = 1'b0;
  logic         stall_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   sel     = 2'd0;
  logic [3:0]   vld_in  = 4'd0;
  logic [127:0] data_in = '0;

  logic [31:0] s_data, r_data, n_data;
  logic        s_vld, r_vld, n_vld;
  logic [3:0]  s_grant, r_grant;
  logic [2:0]  n_grant;
  logic        s_err, r_err, n_err;

  mux_nto1_reg #(.SIZE(32), .NUM(4), .SEL_W(2), .ARB(0)) u_sel (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_in), .valid_i(vld_in),
    .select_i(sel), .stall_i(stall_i), .flush_i(flush_i),
    .data_o(s_data), .valid_o(s_vld), .grant_o(s_grant), .sel_err_o(s_err)
  );

  mux_nto1_reg #(.SIZE(32), .NUM(4), .SEL_W(2), .ARB(1)) u_rr (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_in), .valid_i(vld_in),
    .select_i(sel), .stall_i(stall_i), .flush_i(flush_i),
    .data_o(r_data), .valid_o(r_vld), .grant_o(r_grant), .sel_err_o(r_err)
  );

  mux_nto1_reg #(.SIZE(32), .NUM(3), .SEL_W(2), .ARB(0)) u_n3 (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_in[95:0]), .valid_i(vld_in[2:0]),
    .select_i(sel), .stall_i(stall_i), .flush_i(flush_i),
    .data_o(n_data), .valid_o(n_vld), .grant_o(n_grant), .sel_err_o(n_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  typedef struct {
    int          due;
    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic [3:0]  g0, g1, g2;
    logic        e0, e1, e2;
  } exp_t;

  exp_t exp_q[$];
  exp_t me;

  // Reference model state, index 0 = u_sel, 1 = u_rr, 2 = u_n3
  logic [31:0] m_data  [3];
  logic        m_vld   [3];
  logic [3:0]  m_grant [3];
  logic        m_err   [3];
  int          m_ptr   [3];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endfunction

  task automatic model_step(input int i);
    int  n;
    int  pick;
    int  c;
    bit  found;
    n = (i == 2) ? 3 : 4;
    if (!rst_i) begin
      m_data[i] = '0; m_vld[i] = 1'b0; m_grant[i] = '0; m_err[i] = 1'b0;
      m_ptr[i]  = n - 1;
    end else if (flush_i) begin
      m_data[i] = '0; m_vld[i] = 1'b0; m_grant[i] = '0; m_err[i] = 1'b0;
    end else if (stall_i) begin
      // everything holds
    end else if (i != 1) begin
      if (int'(sel) < n) begin
        m_data[i]  = data_in[int'(sel)*32 +: 32];
        m_vld[i]   = vld_in[sel];
        m_grant[i] = 4'(1 << sel);
        m_err[i]   = 1'b0;
      end else begin
        m_data[i] = '0; m_vld[i] = 1'b0; m_grant[i] = '0; m_err[i] = 1'b1;
      end
    end else begin
      found = 1'b0;
      pick  = 0;
      for (int s = 1; s <= n; s++) begin
        c = (m_ptr[i] + s) % n;
        if (!found && vld_in[c[1:0]]) begin
          found = 1'b1;
          pick  = c;
        end
      end
      m_err[i] = 1'b0;
      if (found) begin
        m_data[i]  = data_in[pick*32 +: 32];
        m_vld[i]   = 1'b1;
        m_grant[i] = 4'(1 << pick);
        m_ptr[i]   = pick;
      end else begin
        m_vld[i]   = 1'b0;
        m_grant[i] = '0;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic s, input logic [1:0] sl,
                       input logic [3:0] v, input logic [127:0] d);
    exp_t e;
    @(posedge clk);
    #1;
    rst_i = r; flush_i = f; stall_i = s; sel = sl; vld_in = v; data_in = d;
    for (int i = 0; i < 3; i++) model_step(i);
    e.due = cyc + 1;
    e.d0 = m_data[0];  e.d1 = m_data[1];  e.d2 = m_data[2];
    e.v0 = m_vld[0];   e.v1 = m_vld[1];   e.v2 = m_vld[2];
    e.g0 = m_grant[0]; e.g1 = m_grant[1]; e.g2 = m_grant[2];
    e.e0 = m_err[0];   e.e1 = m_err[1];   e.e2 = m_err[2];
    exp_q.push_back(e);
  endtask

  // Monitor: one queued expectation per captured edge
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      me = exp_q.pop_front();
      chk("sel_data",  s_data,             me.d0);
      chk("sel_valid", 32'(s_vld),         32'(me.v0));
      chk("sel_grant", 32'(s_grant),       32'(me.g0));
      chk("sel_err",   32'(s_err),         32'(me.e0));
      chk("rr_data",   r_data,             me.d1);
      chk("rr_valid",  32'(r_vld),         32'(me.v1));
      chk("rr_grant",  32'(r_grant),       32'(me.g1));
      chk("rr_err",    32'(r_err),         32'(me.e1));
      chk("n3_data",   n_data,             me.d2);
      chk("n3_valid",  32'(n_vld),         32'(me.v2));
      chk("n3_grant",  32'(n_grant),       32'(me.g2));
      chk("n3_err",    32'(n_err),         32'(me.e2));
      chk("rr_onehot", 32'($countones(r_grant) <= 1), 32'd1);
      chk("sel_onehot", 32'($countones(s_grant) <= 1), 32'd1);
    end
  end

  localparam logic [127:0] D4 = {32'h44, 32'h33, 32'h22, 32'h11};

  initial begin
    // reset, also with stall and flush asserted
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, '0);
    cycle(1'b0, 1'b1, 1'b1, 2'd1, 4'hF, D4);
    // explicit select of channel 2
    cycle(1'b1, 1'b0, 1'b0, 2'd2, 4'hF, D4);
    // out-of-range select on the 3-channel instance, then back in range
    cycle(1'b1, 1'b0, 1'b0, 2'd3, 4'hF, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'hF, D4);
    // data captured even when the selected valid is low
    cycle(1'b1, 1'b0, 1'b0, 2'd1, 4'h5, D4);
    // round-robin from reset with all channels valid
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, D4);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b0, 2'(k), 4'hF, D4);
    // pointer to 1, then wrap to 0, then 1, then idle, then sole valid == ptr
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 4'h0, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h2, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h3, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h3, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h2, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 4'h2, D4);
    // load 0x22, stall with changing inputs, then stall and flush together
    cycle(1'b1, 1'b0, 1'b0, 2'd1, 4'hF, D4);
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b0, 1'b1, 2'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
    cycle(1'b1, 1'b1, 1'b1, 2'd2, 4'hF, D4);
    // reset during a stall with valid output, then first grant after release
    cycle(1'b1, 1'b0, 1'b0, 2'd3, 4'hF, D4);
    cycle(1'b0, 1'b0, 1'b1, 2'd3, 4'hF, D4);
    cycle(1'b1, 1'b0, 1'b0, 2'd1, 4'h6, D4);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 5) == 0), 2'($urandom), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
    end
    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
